dp_job_sequencer: RTL

Job-level controller for the dot-product accelerator. It accepts a job descriptor made of two byte-vector base addresses and a length. It fetches the element pairs from byte memory over the valid/ready read channel and feeds them one pair at a time to the accelerator. It then waits for the accelerator's completion and reports the 32-bit result with a done pulse. It sits between the AXI master's control logic and the memory / dot_product_accelerator pair, replacing free-running start/feed sequencing.

---
 rtl/dp_pkg.sv | 24 ++
 rtl/dp_job_sequencer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/dp_pkg.sv
// Shared types and constants for the dot-product job sequencer.
package dp_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CLEAR,
      S_A_ADDR,
      S_A_DATA,
      S_B_ADDR,
      S_B_DATA,
      S_FEED,
      S_WAIT_DONE,
      S_FINISH
   } state_t;

   localparam int DP_DATA_W = 8;
   localparam int DP_RES_W  = 32;

   // Width of a counter that must be able to hold the value 'timeout'.
   function automatic int tmo_cnt_w(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/dp_job_sequencer.sv
// Job-level controller: fetches byte pairs from memory, feeds them to the
// dot-product accelerator one pair at a time and reports the final result.
module dp_job_sequencer
   import dp_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int LEN_W   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  cfg_start,
   input  logic [ADDR_W-1:0]     cfg_base_a,
   input  logic [ADDR_W-1:0]     cfg_base_b,
   input  logic [LEN_W-1:0]      cfg_len,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [DP_RES_W-1:0]   result,
   output logic [ADDR_W-1:0]     mem_araddr,
   output logic                  mem_arvalid,
   input  logic                  mem_arready,
   input  logic [DP_DATA_W-1:0]  mem_rdata,
   input  logic                  mem_rvalid,
   output logic                  mem_rready,
   output logic [DP_DATA_W-1:0]  dp_a,
   output logic [DP_DATA_W-1:0]  dp_b,
   output logic                  dp_start,
   output logic                  inputs_ready,
   output logic                  dp_last,
   input  logic                  dp_done,
   input  logic [DP_RES_W-1:0]   dp_result
);

   localparam int TCNT_W = tmo_cnt_w(TIMEOUT);

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   base_a_q;
   logic [ADDR_W-1:0]   base_b_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    idx_q;
   logic [TCNT_W-1:0]   tcnt_q;
   logic                is_last;
   logic                tmo_hit;

   assign is_last = (idx_q == (len_q - LEN_W'(1)));
   // The TIMEOUT-th consecutive cycle in WAIT_DONE without dp_done expires the wait.
   assign tmo_hit = (tcnt_q == TCNT_W'(TIMEOUT - 1));

   // State register; reset aborts any job in flight.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic: one outstanding read, A then B, then feed the pair.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (cfg_start) state_nxt = (cfg_len == '0) ? S_FINISH : S_CLEAR;
         S_CLEAR:     state_nxt = S_A_ADDR;
         S_A_ADDR:    if (mem_arready) state_nxt = S_A_DATA;
         S_A_DATA:    if (mem_rvalid)  state_nxt = S_B_ADDR;
         S_B_ADDR:    if (mem_arready) state_nxt = S_B_DATA;
         S_B_DATA:    if (mem_rvalid)  state_nxt = S_FEED;
         S_FEED:      state_nxt = is_last ? S_WAIT_DONE : S_A_ADDR;
         S_WAIT_DONE: if (dp_done || tmo_hit) state_nxt = S_FINISH;
         S_FINISH:    state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   // Output decode; every handshake/pulse output is a pure function of state.
   always_comb begin
      busy         = (state != S_IDLE) && (state != S_FINISH);
      done         = (state == S_FINISH);
      dp_start     = (state == S_CLEAR);
      inputs_ready = (state == S_FEED);
      dp_last      = (state == S_FEED) && is_last;
      mem_arvalid  = (state == S_A_ADDR) || (state == S_B_ADDR);
      mem_rready   = (state == S_A_DATA) || (state == S_B_DATA);
      mem_araddr   = '0;
      if (state == S_A_ADDR) mem_araddr = base_a_q + ADDR_W'(idx_q);
      if (state == S_B_ADDR) mem_araddr = base_b_q + ADDR_W'(idx_q);
   end

   // Job descriptor, element index, timeout counter, operand and status registers.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         base_a_q <= '0;
         base_b_q <= '0;
         len_q    <= '0;
         idx_q    <= '0;
         tcnt_q   <= '0;
         dp_a     <= '0;
         dp_b     <= '0;
         result   <= '0;
         err      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cfg_start) begin
                  base_a_q <= cfg_base_a;
                  base_b_q <= cfg_base_b;
                  len_q    <= cfg_len;
                  result   <= '0;
                  // A zero-length job is reported as an error straight away.
                  err      <= (cfg_len == '0);
               end
            end
            S_CLEAR:  idx_q <= '0;
            S_A_DATA: if (mem_rvalid) dp_a <= mem_rdata;
            S_B_DATA: if (mem_rvalid) dp_b <= mem_rdata;
            S_FEED: begin
               if (is_last) tcnt_q <= '0;
               else         idx_q  <= idx_q + LEN_W'(1);
            end
            S_WAIT_DONE: begin
               // dp_done takes priority over an expiry in the same cycle.
               if (dp_done) begin
                  result <= dp_result;
                  err    <= 1'b0;
               end else if (tmo_hit) begin
                  result <= '0;
                  err    <= 1'b1;
               end else begin
                  tcnt_q <= tcnt_q + TCNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
